// File: rtl/fft_agu_pp.sv
// fft_agu_pp: radix-2 DIT address generator for an in-place FFT with ping-pong banks.
// Issues one butterfly (a, b, twiddle) per non-stalled cycle and replays {a, b} as
// write addresses BFLY_LATENCY non-stalled cycles later.
// Optional macro FFT_AGU_BITREV_EN: stage-0 read addresses are bit-reversed so that
// naturally ordered input is reordered during the first pass.
module fft_agu_pp #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned BFLY_LATENCY = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             stall,
    output logic [ADDR_WIDTH-1:0]            addr_a_rd,
    output logic [ADDR_WIDTH-1:0]            addr_b_rd,
    output logic [ADDR_WIDTH-2:0]            addr_twiddle,
    output logic                             rd_valid,
    output logic [ADDR_WIDTH-1:0]            addr_a_wr,
    output logic [ADDR_WIDTH-1:0]            addr_b_wr,
    output logic                             wr_en,
    output logic                             bank_sel,
    output logic [$clog2(ADDR_WIDTH+1)-1:0]  stage,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned SW = $clog2(ADDR_WIDTH + 1);
    localparam int unsigned DW = (BFLY_LATENCY > 1) ? $clog2(BFLY_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] J_LAST = ADDR_WIDTH'((1 << (ADDR_WIDTH - 1)) - 1);
    localparam logic [DW-1:0]         D_LAST = DW'(BFLY_LATENCY - 1);
    localparam logic [SW-1:0]         S_LAST = SW'(ADDR_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   j_q, j_d;
    logic [DW-1:0]           d_q, d_d;
    logic [SW-1:0]           stage_q, stage_d;
    logic                    bank_q, bank_d;

    logic [BFLY_LATENCY-1:0]                 dl_v_q;
    logic [BFLY_LATENCY-1:0][ADDR_WIDTH-1:0] dl_a_q;
    logic [BFLY_LATENCY-1:0][ADDR_WIDTH-1:0] dl_b_q;

    logic [ADDR_WIDTH-1:0]   half, pos, a_nat, b_nat, a_rd, b_rd;
    logic [ADDR_WIDTH-2:0]   tw;
    logic                    issue;

    // Butterfly address arithmetic for the current (stage, j)
    always_comb begin
        half  = ADDR_WIDTH'(1) << stage_q;
        pos   = j_q & (half - ADDR_WIDTH'(1));
        a_nat = ((j_q >> stage_q) << (stage_q + SW'(1))) | pos;
        b_nat = a_nat | half;
        tw    = (ADDR_WIDTH-1)'(pos << (S_LAST - stage_q));
`ifdef FFT_AGU_BITREV_EN
        a_rd = a_nat;
        b_rd = b_nat;
        if (stage_q == '0) begin
            for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
                a_rd[i] = a_nat[ADDR_WIDTH-1-i];
                b_rd[i] = b_nat[ADDR_WIDTH-1-i];
            end
        end
`else
        a_rd = a_nat;
        b_rd = b_nat;
`endif
    end

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            d_q     <= '0;
            stage_q <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            d_q     <= d_d;
            stage_q <= stage_d;
            bank_q  <= bank_d;
        end
    end

    // Next-state logic; j is held through DRAIN so read addresses stay stable
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        d_d     = d_q;
        stage_d = stage_q;
        bank_d  = bank_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    j_d     = '0;
                    d_d     = '0;
                    stage_d = '0;
                    bank_d  = 1'b0;
                end
            end
            ST_READ: begin
                if (!stall) begin
                    if (j_q == J_LAST) begin
                        state_d = ST_DRAIN;
                        d_d     = '0;
                    end else begin
                        j_d = j_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (d_q == D_LAST) begin
                        j_d    = '0;
                        d_d    = '0;
                        bank_d = ~bank_q;
                        if (stage_q == S_LAST) begin
                            state_d = ST_DONE;
                            stage_d = '0;
                        end else begin
                            state_d = ST_READ;
                            stage_d = stage_q + SW'(1);
                        end
                    end else begin
                        d_d = d_q + DW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-address delay line, frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_v_q <= '0;
            dl_a_q <= '0;
            dl_b_q <= '0;
        end else if (!stall) begin
            dl_v_q[0] <= issue;
            dl_a_q[0] <= issue ? a_nat : '0;
            dl_b_q[0] <= issue ? b_nat : '0;
            for (int unsigned i = 1; i < BFLY_LATENCY; i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                dl_a_q[i] <= dl_a_q[i-1];
                dl_b_q[i] <= dl_b_q[i-1];
            end
        end
    end

    // Output decode; addresses are zero outside an active transform
    always_comb begin
        busy         = (state_q == ST_READ) || (state_q == ST_DRAIN);
        issue        = (state_q == ST_READ) && !stall;
        rd_valid     = issue;
        addr_a_rd    = busy ? a_rd : '0;
        addr_b_rd    = busy ? b_rd : '0;
        addr_twiddle = busy ? tw : '0;
        wr_en        = dl_v_q[BFLY_LATENCY-1] && !stall;
        addr_a_wr    = dl_a_q[BFLY_LATENCY-1];
        addr_b_wr    = dl_b_q[BFLY_LATENCY-1];
        bank_sel     = bank_q;
        stage        = stage_q;
        done         = (state_q == ST_DONE);
    end

endmodule
